// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and width helper for the packed-BCD converters.
package bcd_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned DIGIT_MAX   = 9;
  localparam int unsigned CORR_THRESH = 8;
  localparam int unsigned CORR_VAL    = 3;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Smallest binary width w with 2^w > 10^num_digits - 1.
  function automatic int unsigned min_bin_w(input int unsigned num_digits);
    longint unsigned max_val;
    longint unsigned one;
    int unsigned     w;
    max_val = 1;
    one     = 1;
    w       = 0;
    for (int unsigned i = 0; i < num_digits; i++) begin
      max_val = max_val * 10;
    end
    max_val = max_val - 1;
    while ((one << w) <= max_val) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble digit corrector: a digit of 8 or more has 3 subtracted.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] corrected
);

  always_comb begin
    corrected = digit;
    if (digit >= DIGIT_W'(CORR_THRESH)) begin
      corrected = digit - DIGIT_W'(CORR_VAL);
    end
  end

endmodule

// File: rtl/bcd2binary_reverse_dabble.sv
// Iterative packed-BCD to binary converter, one shift/correct step per clock.
// Optional nibble range check enabled by defining BCD_DIGIT_CHECK_EN (adds the err port).
module bcd2binary_reverse_dabble
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned BIN_W      = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] packed_bcd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              binary_out
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                          err
`endif
);

  localparam int unsigned BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int unsigned SCR_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (NUM_DIGITS < 1 || BIN_W < min_bin_w(NUM_DIGITS)) begin : g_width_check
    $error("BIN_W too small to hold every NUM_DIGITS-digit decimal value");
  end

  state_e             state_q, state_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [BIN_W-1:0]   bin_q, bin_d;

  logic [SCR_W-1:0]   shifted;
  logic [BCD_W-1:0]   bcd_corr;

  assign shifted = scratch_q >> 1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .digit     (shifted[BIN_W + DIGIT_W*g +: DIGIT_W]),
      .corrected (bcd_corr[DIGIT_W*g +: DIGIT_W])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic err_flag_q, err_flag_d;
  logic err_q, err_d;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (packed_bcd[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(DIGIT_MAX)) begin
        bad_digit = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    bin_d       = bin_q;
`ifdef BCD_DIGIT_CHECK_EN
    err_flag_d  = err_flag_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          scratch_d = {packed_bcd, {BIN_W{1'b0}}};
          cnt_d     = '0;
          state_d   = StShift;
`ifdef BCD_DIGIT_CHECK_EN
          err_flag_d = bad_digit;
`endif
        end
      end
      StShift: begin
        scratch_d = {bcd_corr, shifted[BIN_W-1:0]};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
          // Flagged inputs still take the full latency but report zero.
          bin_d = err_flag_q ? '0 : shifted[BIN_W-1:0];
          err_d = err_flag_q;
`else
          bin_d = shifted[BIN_W-1:0];
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
`ifdef BCD_DIGIT_CHECK_EN
          err_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      scratch_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err_flag_q  <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
`ifdef BCD_DIGIT_CHECK_EN
      err_flag_q  <= err_flag_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = out_valid_q;
  assign binary_out = bin_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_bcd2binary_reverse_dabble.sv
// Bench for bcd2binary_reverse_dabble: decimal reference model plus directed vectors.
module tb_bcd2binary_reverse_dabble;

  localparam int unsigned ND = 3;
  localparam int unsigned BW = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4*ND-1:0]   packed_bcd = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [BW-1:0]     binary_out;
`ifdef BCD_DIGIT_CHECK_EN
  logic              err;
`endif

  bcd2binary_reverse_dabble #(
    .NUM_DIGITS (ND),
    .BIN_W      (BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .packed_bcd (packed_bcd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .binary_out (binary_out)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] bin;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   n_in = 0;
  int   n_out = 0;
  int   n_flushed = 0;
  bit   prev_ov = 1'b0;
  bit   rand_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  // Decimal value of the digits; out-of-range nibbles flag an error.
  function automatic exp_t model(input logic [4*ND-1:0] b);
    exp_t e;
    int   v;
    bit   bad;
    v   = 0;
    bad = 1'b0;
    for (int i = ND - 1; i >= 0; i--) begin
      int d;
      d = int'(b[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      v = v * 10 + d;
    end
    e.bin = BW'(v);
    e.err = bad;
`ifdef BCD_DIGIT_CHECK_EN
    if (bad) e.bin = '0;
`endif
    return e;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] b;
    int              r;
    r = v;
    for (int i = 0; i < ND; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  // Compare process: runs every cycle against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      n_flushed = n_flushed + exp_q.size();
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_binary_out", binary_out, 0);
`ifdef BCD_DIGIT_CHECK_EN
      check("rst_err", err, 0);
`endif
      prev_ov = 1'b0;
    end else begin
      check("in_ready_vs_model", in_ready, exp_q.size() == 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          check("binary_out_vs_model", binary_out, exp_q[0].bin);
`ifdef BCD_DIGIT_CHECK_EN
          check("err_vs_model", err, exp_q[0].err);
`endif
          if (!prev_ov) check("latency_edges", cyc - acc_edge, BW);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(packed_bcd));
        acc_edge = cyc + 1;
        n_in++;
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [4*ND-1:0] v);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!in_ready && n < 200);
    check("send_in_ready", in_ready, 1);
    if (in_ready) begin
      in_valid   = 1'b1;
      packed_bcd = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check("out_valid_seen", out_valid, 1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    int w;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_binary_out", binary_out, 0);
    rst_n = 1'b1;

    send(12'h255);
    wait_out(n);
    check("lat_255", n, 11);
    check("bin_255", binary_out, 255);

    send(12'h999);
    wait_out(n);
    check("lat_999", n, 11);
    check("bin_999", binary_out, 10'h3E7);

    send(12'h000);
    wait_out(n);
    check("lat_000", n, 11);
    check("bin_000", binary_out, 0);

    // Back-pressure with a competing input held during the stall.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(12'h128);
    wait_out(n);
    in_valid   = 1'b1;
    packed_bcd = 12'h256;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_bin_128", binary_out, 128);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_stall", in_ready, 1);
    check("out_valid_dropped", out_valid, 0);
    check("bin_held_after_hs", binary_out, 128);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("second_accepted", in_ready, 0);
    wait_out(n);
    check("bin_256", binary_out, 256);

    // Abort mid-conversion.
    @(posedge clk);
    #1;
    send(12'h777);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_binary_out", binary_out, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(12'h042);
    wait_out(n);
    check("lat_042", n, 11);
    check("bin_042", binary_out, 42);

`ifdef BCD_DIGIT_CHECK_EN
    send(12'h1A3);
    wait_out(n);
    check("lat_1a3", n, 11);
    check("err_1a3", err, 1);
    check("bin_1a3", binary_out, 0);
    send(12'h103);
    wait_out(n);
    check("err_103", err, 0);
    check("bin_103", binary_out, 103);
`endif

    // Full decimal sweep with random back-pressure.
    @(posedge clk);
    #1;
    base    = n_in;
    rand_en = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      send(to_bcd(v));
    end
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    rand_en = 1'b0;
    #1;
    out_ready = 1'b1;
    check("sweep_drained", exp_q.size(), 0);
    check("sweep_accepted", n_in - base, 1000);
    check("in_out_balance", n_out + n_flushed, n_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
